dmem_block_mover: RTL and testbench
===================================

Name: dmem_block_mover

Overview:
- Bus-initiator engine that drives the data memory port (addr, write_data, read_data, MemRead, MemWrite) from the master side.
- Performs word-granular block copy (memory to memory) or block fill (constant pattern) without processor involvement.
- Sits beside the CPU datapath on the data memory port; a top-level mux grants the port to this block while busy=1.

Parameters:
- ADDR_W, 8, byte-address width of the memory port.
- DATA_W, 32, word width.
- LEN_W, 7, width of the word-count input (max 64 words).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill.
- src_addr  input  ADDR_W  copy source byte address; bits [1:0] ignored, forced to 00.
- dst_addr  input  ADDR_W  destination byte address; bits [1:0] forced to 00.
- length  input  LEN_W  number of words to transfer.
- fill_data  input  DATA_W  pattern used in fill mode.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle completion pulse.
- words_done  output  LEN_W  count of words written in the current or last transfer.
- addr  output  ADDR_W  memory byte address.
- write_data  output  DATA_W  memory write data.
- read_data  input  DATA_W  memory read data; combinational, valid in the same cycle MemRead=1.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe; memory commits on the rising edge.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset: state=IDLE; busy, done, MemRead and MemWrite = 0; addr, write_data and words_done = 0; internal pointers, remaining count and data buffer = 0.
- States: IDLE, RD, WR, DONE.
- IDLE, start=1: latch src_ptr={src_addr[7:2],00}, dst_ptr={dst_addr[7:2],00}, remaining=length, mode, fill_data; clear words_done.
  - length=0: go to DONE.
  - mode=0: go to RD.
  - mode=1: go to WR.
- RD: MemRead=1, addr=src_ptr. At the edge, capture read_data into buf; src_ptr += 4; go to WR.
- WR: MemWrite=1, addr=dst_ptr, write_data = buf (copy) or latched fill_data (fill). At the edge: dst_ptr += 4, remaining -= 1, words_done += 1.
  - remaining was 1: go to DONE.
  - otherwise: go to RD (copy) or stay in WR (fill).
- DONE: done=1 for exactly one cycle, busy=0, strobes 0; go to IDLE.
- Output decode: memory-side outputs decode from state and registers only; no combinational path from start/inputs to addr, MemRead or MemWrite.
- busy: =1 in RD and WR. MemRead and MemWrite are never high together.
- Idle drive: in IDLE/DONE, addr and write_data hold their last driven values.
- Latency:
  - start sampled at edge T; first memory strobe in cycle T+1.
  - Copy of N words: 2N strobe cycles, done in cycle T+2N+1.
  - Fill of N words: N cycles, done in cycle T+N+1.
  - length=0: done in cycle T+1, no strobes.
- start while busy or in DONE: ignored, no queuing.
- Inputs are latched at start; changes to them mid-transfer have no effect.
- Pointer arithmetic is modulo 2^ADDR_W; 0xFC + 4 wraps to 0x00 silently.
- Overlap: copy is strictly ascending, one word at a time. When dst > src and the ranges overlap, the source is overwritten before it is read; no correction is made.
- Reset mid-transfer: at the reset edge all strobes drop, no done pulse is issued, and writes already committed remain in memory.

Test Plan:
- Copy: preload words 0x11,0x22,0x33 at bytes 0x00/0x04/0x08; start mode=0 src=0x00 dst=0x40 len=3.
  - Strobes alternate RD/WR for 6 cycles; addr sequence 00,40,04,44,08,48.
  - Memory 0x40..0x48 = 0x11,0x22,0x33; done pulses once; words_done=3.
- Fill: mode=1 dst=0x10 len=4 fill_data=0xDEADBEEF.
  - 4 consecutive MemWrite cycles, addr 10,14,18,1C, all 0xDEADBEEF.
  - MemRead stays 0; done in cycle T+5.
- Zero length / misaligned: len=0 -> done at T+1, no strobes. src=0x07 -> first read addr 0x04.
- Wrap: fill dst=0xF8 len=3 -> addr F8,FC,00.
- start asserted during busy: second request is ignored and the first transfer completes unchanged.
- Reset asserted in the 3rd cycle of a 4-word copy: next cycle state=IDLE, busy=0, done never asserted, only word 0 written. A new start afterwards runs normally.

Source files
------------

// File: rtl/dmem_block_mover_if.sv
// Bundle of the block mover's command, status and data memory port signals.
// The master view belongs to the mover. The slave view belongs to whoever
// issues commands and answers the memory port.
interface dmem_block_mover_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 7
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] fill_data;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  words_done;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              MemRead;
    logic              MemWrite;

    modport master (
        input  start, mode, src_addr, dst_addr, length, fill_data, read_data,
        output busy, done, words_done, addr, write_data, MemRead, MemWrite
    );

    modport slave (
        output start, mode, src_addr, dst_addr, length, fill_data, read_data,
        input  busy, done, words_done, addr, write_data, MemRead, MemWrite
    );
endinterface

// File: rtl/dmem_block_mover.sv
// Word-granular block copy / block fill engine that masters the data memory
// port. Copy alternates one read cycle and one write cycle per word, walking
// both pointers upward. Fill writes the latched pattern on every cycle.
// The memory-side outputs depend only on state and registers.
module dmem_block_mover #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 7
) (
    input  logic                clk,
    input  logic                reset,
    dmem_block_mover_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    localparam logic [LEN_W-1:0]  ONE_WORD  = LEN_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [LEN_W-1:0]  words_done_q, words_done_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_wdata_q, last_wdata_d;

    logic [DATA_W-1:0] wr_word;

    // Word presented during a write: the buffered read for copy, the pattern for fill
    always_comb begin
        wr_word = mode_q ? fill_q : buf_q;
    end

    // Next-state and datapath updates for the transfer sequencer
    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        mode_d       = mode_q;
        fill_d       = fill_q;
        buf_d        = buf_q;
        last_addr_d  = last_addr_q;
        last_wdata_d = last_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Byte offsets inside a word are dropped; transfers are word aligned.
                    src_ptr_d    = {bus.src_addr[ADDR_W-1:2], 2'b00};
                    dst_ptr_d    = {bus.dst_addr[ADDR_W-1:2], 2'b00};
                    remaining_d  = bus.length;
                    mode_d       = bus.mode;
                    fill_d       = bus.fill_data;
                    words_done_d = '0;
                    if (bus.length == '0) begin
                        state_d = DONE;
                    end else if (bus.mode) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                buf_d       = bus.read_data;
                src_ptr_d   = src_ptr_q + WORD_STEP;
                last_addr_d = src_ptr_q;
                state_d     = WR;
            end
            WR: begin
                dst_ptr_d    = dst_ptr_q + WORD_STEP;
                remaining_d  = remaining_q - ONE_WORD;
                words_done_d = words_done_q + ONE_WORD;
                last_addr_d  = dst_ptr_q;
                last_wdata_d = wr_word;
                if (remaining_q == ONE_WORD) begin
                    state_d = DONE;
                end else if (mode_q) begin
                    state_d = WR;
                end else begin
                    state_d = RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered state, pointers, counters and held bus values
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            mode_q       <= 1'b0;
            fill_q       <= '0;
            buf_q        <= '0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            mode_q       <= mode_d;
            fill_q       <= fill_d;
            buf_q        <= buf_d;
            last_addr_q  <= last_addr_d;
            last_wdata_q <= last_wdata_d;
        end
    end

    // Port decode from state and registers only; the bus holds its last values when idle
    always_comb begin
        bus.busy       = (state_q == RD) || (state_q == WR);
        bus.done       = (state_q == DONE);
        bus.MemRead    = (state_q == RD);
        bus.MemWrite   = (state_q == WR);
        bus.words_done = words_done_q;
        bus.addr       = last_addr_q;
        bus.write_data = last_wdata_q;
        case (state_q)
            RD: begin
                bus.addr = src_ptr_q;
            end
            WR: begin
                bus.addr       = dst_ptr_q;
                bus.write_data = wr_word;
            end
            default: begin
                bus.addr       = last_addr_q;
                bus.write_data = last_wdata_q;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_block_mover.sv
// Directed bench for dmem_block_mover: a 64-word memory model answers the
// port, and each transfer is traced cycle by cycle after its start edge.
module tb_dmem_block_mover;

    logic clk;
    logic reset;

    dmem_block_mover_if #(.ADDR_W(8), .DATA_W(32), .LEN_W(7)) bus ();

    dmem_block_mover #(.ADDR_W(8), .DATA_W(32), .LEN_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model
    logic [31:0] mem [64];
    logic        mem_clr;
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    assign bus.read_data = mem[bus.addr[7:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (bus.MemWrite) begin
            mem[bus.addr[7:2]] <= bus.write_data;
        end else if (pl_we) begin
            mem[pl_idx] <= pl_data;
        end
    end

    int n_vec;
    int n_miss;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_idx  = 6'(idx);
        pl_data = data;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    // Per-cycle trace; index k is cycle T+k after the start edge T
    logic        tr_rd   [41];
    logic        tr_wr   [41];
    logic        tr_busy [41];
    logic [7:0]  tr_addr [41];
    logic [31:0] tr_wd   [41];
    int          done_cyc;
    int          done_cnt;
    int          n_strobe;
    int          overlap;

    // hook_kind: 0 none, 1 second start during busy, 2 reset pulse
    task automatic run_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                            input logic [6:0] len, input logic [31:0] f,
                            input int maxc, input int hook_cyc, input int hook_kind);
        @(negedge clk);
        bus.mode      = m;
        bus.src_addr  = s;
        bus.dst_addr  = d;
        bus.length    = len;
        bus.fill_data = f;
        bus.start     = 1'b1;
        done_cyc = -1;
        done_cnt = 0;
        n_strobe = 0;
        overlap  = 0;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            bus.start  = 1'b0;
            tr_rd[k]   = bus.MemRead;
            tr_wr[k]   = bus.MemWrite;
            tr_busy[k] = bus.busy;
            tr_addr[k] = bus.addr;
            tr_wd[k]   = bus.write_data;
            if (bus.MemRead || bus.MemWrite) n_strobe++;
            if (bus.MemRead && bus.MemWrite) overlap++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            reset = 1'b0;
            if (hook_kind == 1 && k == hook_cyc) begin
                bus.start     = 1'b1;
                bus.mode      = 1'b1;
                bus.dst_addr  = 8'h60;
                bus.length    = 7'd5;
                bus.fill_data = 32'h00000BAD;
            end
            if (hook_kind == 2 && k == hook_cyc) reset = 1'b1;
        end
    endtask

    logic [7:0] cp_addr [6];

    initial begin
        n_vec = 0;
        n_miss = 0;
        reset = 1'b1;
        mem_clr = 1'b1;
        pl_we = 1'b0;
        pl_idx = '0;
        pl_data = '0;
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.length = '0;
        bus.fill_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rd", 32'(bus.MemRead), 32'd0);
        check("rst_wr", 32'(bus.MemWrite), 32'd0);
        check("rst_addr", 32'(bus.addr), 32'h0);
        check("rst_wdata", bus.write_data, 32'h0);
        check("rst_words", 32'(bus.words_done), 32'd0);
        reset = 1'b0;
        mem_clr = 1'b0;

        // Copy three words 0x00 -> 0x40
        preload(0, 32'h11);
        preload(1, 32'h22);
        preload(2, 32'h33);
        cp_addr = '{8'h00, 8'h40, 8'h04, 8'h44, 8'h08, 8'h48};
        run_xfer(1'b0, 8'h00, 8'h40, 7'd3, 32'h0, 10, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("cp_rd%0d", k), 32'(tr_rd[k]), 32'(k % 2));
            check($sformatf("cp_wr%0d", k), 32'(tr_wr[k]), 32'((k + 1) % 2));
            check($sformatf("cp_addr%0d", k), 32'(tr_addr[k]), 32'(cp_addr[k-1]));
        end
        check("cp_wd2", tr_wd[2], 32'h11);
        check("cp_wd6", tr_wd[6], 32'h33);
        check("cp_done_cyc", 32'(done_cyc), 32'd7);
        check("cp_done_cnt", 32'(done_cnt), 32'd1);
        check("cp_strobes", 32'(n_strobe), 32'd6);
        check("cp_excl", 32'(overlap), 32'd0);
        check("cp_words", 32'(bus.words_done), 32'd3);
        check("cp_m40", mem[16], 32'h11);
        check("cp_m44", mem[17], 32'h22);
        check("cp_m48", mem[18], 32'h33);
        check("cp_hold_addr", 32'(bus.addr), 32'h48);

        // Fill four words at 0x10
        run_xfer(1'b1, 8'h00, 8'h10, 7'd4, 32'hDEADBEEF, 8, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("fl_wr%0d", k), 32'(tr_wr[k]), 32'd1);
            check($sformatf("fl_addr%0d", k), 32'(tr_addr[k]), 32'h10 + 32'(4 * (k - 1)));
            check($sformatf("fl_wd%0d", k), tr_wd[k], 32'hDEADBEEF);
            check($sformatf("fl_mem%0d", k), mem[4 + k - 1], 32'hDEADBEEF);
        end
        check("fl_strobes", 32'(n_strobe), 32'd4);
        check("fl_done_cyc", 32'(done_cyc), 32'd5);
        check("fl_words", 32'(bus.words_done), 32'd4);

        // Zero length
        run_xfer(1'b0, 8'h00, 8'h40, 7'd0, 32'h0, 4, 0, 0);
        check("z_done_cyc", 32'(done_cyc), 32'd1);
        check("z_strobes", 32'(n_strobe), 32'd0);
        check("z_words", 32'(bus.words_done), 32'd0);

        // Misaligned source/destination, one word
        run_xfer(1'b0, 8'h07, 8'h82, 7'd1, 32'h0, 5, 0, 0);
        check("ma_rd_addr", 32'(tr_addr[1]), 32'h04);
        check("ma_wr_addr", 32'(tr_addr[2]), 32'h80);
        check("ma_done_cyc", 32'(done_cyc), 32'd3);
        check("ma_mem80", mem[32], 32'h22);

        // Wrapping fill
        run_xfer(1'b1, 8'h00, 8'hF8, 7'd3, 32'hA5A50001, 6, 0, 0);
        check("wr_addr1", 32'(tr_addr[1]), 32'hF8);
        check("wr_addr2", 32'(tr_addr[2]), 32'hFC);
        check("wr_addr3", 32'(tr_addr[3]), 32'h00);
        check("wr_memF8", mem[62], 32'hA5A50001);
        check("wr_memFC", mem[63], 32'hA5A50001);
        check("wr_mem00", mem[0], 32'hA5A50001);

        // Second start while busy is ignored
        preload(12, 32'hCAFE0001);
        preload(13, 32'hCAFE0002);
        run_xfer(1'b0, 8'h30, 8'h50, 7'd2, 32'h0, 10, 2, 1);
        check("sb_addr3", 32'(tr_addr[3]), 32'h34);
        check("sb_addr4", 32'(tr_addr[4]), 32'h54);
        check("sb_rd3", 32'(tr_rd[3]), 32'd1);
        check("sb_done_cyc", 32'(done_cyc), 32'd5);
        check("sb_strobes", 32'(n_strobe), 32'd4);
        check("sb_words", 32'(bus.words_done), 32'd2);
        check("sb_mem50", mem[20], 32'hCAFE0001);
        check("sb_mem54", mem[21], 32'hCAFE0002);
        check("sb_mem60", mem[24], 32'h0);

        // Reset in the 3rd cycle of a 4-word copy
        preload(36, 32'h1000_0001);
        preload(37, 32'h1000_0002);
        preload(38, 32'h1000_0003);
        preload(39, 32'h1000_0004);
        run_xfer(1'b0, 8'h90, 8'hA0, 7'd4, 32'h0, 10, 3, 2);
        check("rs_rd3", 32'(tr_rd[3]), 32'd1);
        check("rs_busy4", 32'(tr_busy[4]), 32'd0);
        check("rs_strobe4", 32'(tr_rd[4] | tr_wr[4]), 32'd0);
        check("rs_done_cnt", 32'(done_cnt), 32'd0);
        check("rs_strobes", 32'(n_strobe), 32'd3);
        check("rs_words", 32'(bus.words_done), 32'd0);
        check("rs_memA0", mem[40], 32'h1000_0001);
        check("rs_memA4", mem[41], 32'h0);

        // Fresh transfer after reset
        run_xfer(1'b0, 8'h90, 8'hA0, 7'd4, 32'h0, 12, 0, 0);
        check("rn_done_cyc", 32'(done_cyc), 32'd9);
        check("rn_words", 32'(bus.words_done), 32'd4);
        check("rn_memA4", mem[41], 32'h1000_0002);
        check("rn_memAC", mem[43], 32'h1000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
